// File: rtl/vga_dec_pkg.sv
// rtl/vga_dec_pkg.sv - shared types and constants for the VGA timing decoder
package vga_dec_pkg;

   localparam int CNT_W      = 12;
   localparam int LOCK_CNT_W = 4;

   localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(4095);
   localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
   localparam logic [LOCK_CNT_W-1:0] LOCK_ONE = LOCK_CNT_W'(1);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } dec_state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - two-flop sync sampler with fall/rise pulses
// Flops idle high so a line held low out of reset reads as a falling edge.
module vga_sync_edge (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic sync_i,
   output logic s1_o,
   output logic fall_o,
   output logic rise_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= sync_i;
         s2_q <= s1_q;
      end
   end

   assign s1_o   = s1_q;
   assign fall_o = s2_q & ~s1_q;
   assign rise_o = ~s2_q & s1_q;

endmodule

// File: rtl/vga_timing_decoder.sv
// rtl/vga_timing_decoder.sv - VGA receive timing decoder: locks on sync timing, regenerates active X/Y
// Optional sync low-width measurement enabled by VGA_DEC_SYNC_WIDTH_EN.
module vga_timing_decoder
   import vga_dec_pkg::*;
#(
   parameter int X_START     = 144,
   parameter int H_ACT       = 640,
   parameter int Y_START     = 35,
   parameter int V_ACT       = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iVGA_H_SYNC,
   input  logic        iVGA_V_SYNC,
   input  logic [9:0]  iVGA_R,
   input  logic [9:0]  iVGA_G,
   input  logic [9:0]  iVGA_B,
   output logic [9:0]  oR,
   output logic [9:0]  oG,
   output logic [9:0]  oB,
   output logic [11:0] oX,
   output logic [11:0] oY,
   output logic        oPixel_Valid,
   output logic        oLine_Start,
   output logic        oFrame_Start,
   output logic        oLocked,
   output logic [11:0] oH_Total,
   output logic [11:0] oV_Total,
   output logic [11:0] oH_Sync_Width,
   output logic [11:0] oV_Sync_Width
);

   localparam logic [CNT_W-1:0]      X_LO     = CNT_W'(X_START);
   localparam logic [CNT_W-1:0]      X_HI     = CNT_W'(X_START + H_ACT);
   localparam logic [CNT_W-1:0]      Y_LO     = CNT_W'(Y_START);
   localparam logic [CNT_W-1:0]      Y_HI     = CNT_W'(Y_START + V_ACT);
   localparam logic [LOCK_CNT_W-1:0] LOCK_TGT = LOCK_CNT_W'(LOCK_FRAMES);

   logic h_s1, h_fall, h_rise;
   logic v_s1, v_fall, v_rise;

   vga_sync_edge u_h_edge (
      .clk_i   (iCLK),
      .rst_n_i (iRST_N),
      .sync_i  (iVGA_H_SYNC),
      .s1_o    (h_s1),
      .fall_o  (h_fall),
      .rise_o  (h_rise)
   );

   vga_sync_edge u_v_edge (
      .clk_i   (iCLK),
      .rst_n_i (iRST_N),
      .sync_i  (iVGA_V_SYNC),
      .s1_o    (v_s1),
      .fall_o  (v_fall),
      .rise_o  (v_rise)
   );

   // Pixel data rides two stages so it lines up with the s2 sync stage and counters
   logic [29:0] rgb_s1_q, rgb_s2_q;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         rgb_s1_q <= '0;
         rgb_s2_q <= '0;
      end else begin
         rgb_s1_q <= {iVGA_R, iVGA_G, iVGA_B};
         rgb_s2_q <= rgb_s1_q;
      end
   end

   logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
   logic [CNT_W-1:0] line_len, frame_len;

   always_comb begin
      h_cnt_d = h_fall ? '0 : sat_inc(h_cnt_q);
      v_cnt_d = v_cnt_q;
      if (v_fall) begin
         v_cnt_d = '0;
      end else if (h_fall) begin
         v_cnt_d = sat_inc(v_cnt_q);
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign line_len  = h_cnt_q + CNT_ONE;
   assign frame_len = v_cnt_q + CNT_ONE;

   dec_state_e            state_q;
   logic                  h_seen_q;
   logic                  h_ref_valid_q;
   logic                  v_ref_valid_q;
   logic [CNT_W-1:0]      h_ref_q;
   logic [CNT_W-1:0]      v_ref_q;
   logic [LOCK_CNT_W-1:0] match_cnt_q;
   logic [LOCK_CNT_W-1:0] match_inc;
   logic                  h_mismatch, v_mismatch, sig_lost;

   assign match_inc  = match_cnt_q + LOCK_ONE;
   assign h_mismatch = h_fall && h_ref_valid_q && (line_len != h_ref_q);
   assign v_mismatch = v_fall && v_ref_valid_q && (frame_len != v_ref_q);
   assign sig_lost   = (h_cnt_q == CNT_MAX) || (v_cnt_q == CNT_MAX);

   // A saturated counter means sync has stopped toggling; drop back to SEARCH
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q       <= SEARCH;
         h_seen_q      <= 1'b0;
         h_ref_valid_q <= 1'b0;
         v_ref_valid_q <= 1'b0;
         h_ref_q       <= '0;
         v_ref_q       <= '0;
         match_cnt_q   <= '0;
      end else begin
         if (h_fall) begin
            h_seen_q <= 1'b1;
         end
         case (state_q)
            SEARCH: begin
               if (v_fall) begin
                  state_q       <= MEASURE;
                  h_ref_valid_q <= 1'b0;
                  v_ref_valid_q <= 1'b0;
                  match_cnt_q   <= '0;
               end
            end
            MEASURE, LOCKED: begin
               if (sig_lost || h_mismatch || v_mismatch) begin
                  state_q <= SEARCH;
               end else begin
                  if (h_fall && h_seen_q && !h_ref_valid_q) begin
                     h_ref_q       <= line_len;
                     h_ref_valid_q <= 1'b1;
                  end
                  if (v_fall) begin
                     if (!v_ref_valid_q) begin
                        v_ref_q       <= frame_len;
                        v_ref_valid_q <= 1'b1;
                     end else if (state_q == MEASURE) begin
                        match_cnt_q <= match_inc;
                        if (match_inc == LOCK_TGT) begin
                           state_q <= LOCKED;
                        end
                     end
                  end
               end
            end
            default: state_q <= SEARCH;
         endcase
      end
   end

   logic             locked_st;
   logic             pix_valid;
   logic [CNT_W-1:0] x_d, y_d;

   assign locked_st = (state_q == LOCKED);
   assign pix_valid = locked_st
                      && (h_cnt_q >= X_LO) && (h_cnt_q < X_HI)
                      && (v_cnt_q >= Y_LO) && (v_cnt_q < Y_HI);
   assign x_d = h_cnt_q - X_LO;
   assign y_d = v_cnt_q - Y_LO;

   logic             valid_q, line_start_q, frame_start_q, locked_q;
   logic [29:0]      rgb_q;
   logic [CNT_W-1:0] x_q, y_q, h_total_q, v_total_q;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         valid_q       <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         rgb_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         h_total_q     <= '0;
         v_total_q     <= '0;
      end else begin
         valid_q       <= pix_valid;
         line_start_q  <= pix_valid && (x_d == '0);
         frame_start_q <= pix_valid && (x_d == '0) && (y_d == '0);
         locked_q      <= locked_st;
         rgb_q         <= pix_valid ? rgb_s2_q : '0;
         x_q           <= pix_valid ? x_d : '0;
         y_q           <= pix_valid ? y_d : '0;
         h_total_q     <= locked_st ? h_ref_q : '0;
         v_total_q     <= locked_st ? v_ref_q : '0;
      end
   end

   assign oR           = rgb_q[29:20];
   assign oG           = rgb_q[19:10];
   assign oB           = rgb_q[9:0];
   assign oX           = x_q;
   assign oY           = y_q;
   assign oPixel_Valid = valid_q;
   assign oLine_Start  = line_start_q;
   assign oFrame_Start = frame_start_q;
   assign oLocked      = locked_q;
   assign oH_Total     = h_total_q;
   assign oV_Total     = v_total_q;

`ifdef VGA_DEC_SYNC_WIDTH_EN
   logic [CNT_W-1:0] hw_cnt_q, vw_cnt_q, hw_lat_q, vw_lat_q, hsw_q, vsw_q;

   // H width counts clocks low; V width counts line starts seen while vsync is low
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         hw_cnt_q <= '0;
         vw_cnt_q <= '0;
         hw_lat_q <= '0;
         vw_lat_q <= '0;
         hsw_q    <= '0;
         vsw_q    <= '0;
      end else begin
         if (h_fall) begin
            hw_cnt_q <= CNT_ONE;
         end else if (!h_s1) begin
            hw_cnt_q <= sat_inc(hw_cnt_q);
         end
         if (h_rise) begin
            hw_lat_q <= hw_cnt_q;
         end
         if (v_fall) begin
            vw_cnt_q <= CNT_ONE;
         end else if (!v_s1 && h_fall) begin
            vw_cnt_q <= sat_inc(vw_cnt_q);
         end
         if (v_rise) begin
            vw_lat_q <= vw_cnt_q;
         end
         hsw_q <= locked_st ? hw_lat_q : '0;
         vsw_q <= locked_st ? vw_lat_q : '0;
      end
   end

   assign oH_Sync_Width = hsw_q;
   assign oV_Sync_Width = vsw_q;
`else
   logic unused_sync_sig;

   assign unused_sync_sig = ^{h_s1, h_rise, v_s1, v_rise};
   assign oH_Sync_Width   = '0;
   assign oV_Sync_Width   = '0;
`endif

endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb/tb_vga_timing_decoder.sv - scoreboard bench for vga_timing_decoder on a reduced raster
`timescale 1ns/1ps
module tb_vga_timing_decoder;

   localparam int X_ST  = 10;
   localparam int H_A   = 16;
   localparam int Y_ST  = 4;
   localparam int V_A   = 6;
   localparam int H_TOT = 40;
   localparam int V_TOT = 14;
   localparam int HSW   = 4;
   localparam int VSW   = 2;

`ifdef VGA_DEC_SYNC_WIDTH_EN
   localparam int EXP_HSW = HSW;
   localparam int EXP_VSW = VSW;
`else
   localparam int EXP_HSW = 0;
   localparam int EXP_VSW = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hs, vs;
   logic [9:0]  r_in, g_in, b_in;
   logic [9:0]  oR, oG, oB;
   logic [11:0] oX, oY, oH_Total, oV_Total, oH_Sync_Width, oV_Sync_Width;
   logic        oPixel_Valid, oLine_Start, oFrame_Start, oLocked;

   vga_timing_decoder #(
      .X_START     (X_ST),
      .H_ACT       (H_A),
      .Y_START     (Y_ST),
      .V_ACT       (V_A),
      .LOCK_FRAMES (2)
   ) dut (
      .iCLK          (clk),
      .iRST_N        (rst_n),
      .iVGA_H_SYNC   (hs),
      .iVGA_V_SYNC   (vs),
      .iVGA_R        (r_in),
      .iVGA_G        (g_in),
      .iVGA_B        (b_in),
      .oR            (oR),
      .oG            (oG),
      .oB            (oB),
      .oX            (oX),
      .oY            (oY),
      .oPixel_Valid  (oPixel_Valid),
      .oLine_Start   (oLine_Start),
      .oFrame_Start  (oFrame_Start),
      .oLocked       (oLocked),
      .oH_Total      (oH_Total),
      .oV_Total      (oV_Total),
      .oH_Sync_Width (oH_Sync_Width),
      .oV_Sync_Width (oV_Sync_Width)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic [9:0]  r;
      logic [9:0]  g;
      logic [9:0]  b;
      logic        ls;
      logic        fs;
   } px_t;

   typedef struct packed {
      logic [31:0] at;
      logic        lvl;
   } lk_t;

   px_t px_q[$];
   lk_t lk_q[$];
   int  n_cmp = 0;
   int  n_err = 0;
   int  last_hfall_cyc = 0;
   bit  mon_en = 1'b0;
   logic prev_locked = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      px_t e;
      lk_t l;
      #1;
      if (mon_en) begin
         if (oLocked !== prev_locked) begin
            if (lk_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL lock_edge: unexpected oLocked edge to %0b at cycle %0d", oLocked, cyc);
            end else begin
               l = lk_q.pop_front();
               chk("lock_edge_cycle", cyc, l.at);
               chk("lock_edge_level", {31'b0, oLocked}, {31'b0, l.lvl});
            end
         end
         prev_locked = oLocked;
         if (oPixel_Valid) begin
            if (px_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL pixel: unexpected valid at x=%0d y=%0d cycle %0d", oX, oY, cyc);
            end else begin
               e = px_q.pop_front();
               chk("px_x", {20'b0, oX}, {20'b0, e.x});
               chk("px_y", {20'b0, oY}, {20'b0, e.y});
               chk("px_r", {22'b0, oR}, {22'b0, e.r});
               chk("px_g", {22'b0, oG}, {22'b0, e.g});
               chk("px_b", {22'b0, oB}, {22'b0, e.b});
               chk("px_line_start", {31'b0, oLine_Start}, {31'b0, e.ls});
               chk("px_frame_start", {31'b0, oFrame_Start}, {31'b0, e.fs});
            end
         end else begin
            chk("idle_rgb_pulses", {oR[0 +: 10] , oG[9:8], oB[9:0] | oG[7:0], oLine_Start, oFrame_Start}, 32'd0);
         end
      end else begin
         prev_locked = 1'b0;
      end
   end

   task automatic drive_frame(input bit exp_v, input int bad_line, input int stop_px, input bit lock_rise);
      for (int gy = 0; gy < V_TOT; gy++) begin
         int len;
         len = (gy == bad_line) ? H_TOT + 1 : H_TOT;
         for (int gx = 0; gx < len; gx++) begin
            if (gy * H_TOT + gx == stop_px) return;
            @(negedge clk);
            hs   = (gx < HSW) ? 1'b0 : 1'b1;
            vs   = (gy < VSW) ? 1'b0 : 1'b1;
            r_in = 10'(gx);
            g_in = 10'(gy);
            b_in = 10'((gx * 7 + gy * 13) & 1023);
            if (gx == 0) last_hfall_cyc = cyc;
            if (gx == 0 && gy == 0 && lock_rise) lk_q.push_back('{at: 32'(cyc + 3), lvl: 1'b1});
            if (gx == 0 && bad_line >= 0 && gy == bad_line + 1)
               lk_q.push_back('{at: 32'(cyc + 3), lvl: 1'b0});
            if (exp_v && (bad_line < 0 || gy <= bad_line) &&
                gx >= X_ST && gx < X_ST + H_A && gy >= Y_ST && gy < Y_ST + V_A)
               px_q.push_back('{x: 12'(gx - X_ST), y: 12'(gy - Y_ST),
                                r: 10'(gx), g: 10'(gy), b: 10'((gx * 7 + gy * 13) & 1023),
                                ls: (gx == X_ST), fs: (gx == X_ST && gy == Y_ST)});
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_locked"}, {31'b0, oLocked}, 32'd0);
      chk({tag, "_valid"}, {31'b0, oPixel_Valid}, 32'd0);
      chk({tag, "_rgb"}, {2'b0, oR, oG, oB}, 32'd0);
      chk({tag, "_xy"}, {8'b0, oX, oY}, 32'd0);
      chk({tag, "_pulses"}, {30'b0, oLine_Start, oFrame_Start}, 32'd0);
      chk({tag, "_totals"}, {8'b0, oH_Total, oV_Total}, 32'd0);
      chk({tag, "_sync_w"}, {8'b0, oH_Sync_Width, oV_Sync_Width}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      hs = 1'b1;
      vs = 1'b1;
      r_in = '0;
      g_in = '0;
      b_in = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n  = 1'b1;
      mon_en = 1'b1;

      repeat (3) drive_frame(1'b0, -1, -1, 1'b0);
      drive_frame(1'b1, -1, -1, 1'b1);
      drive_frame(1'b1, -1, -1, 1'b0);
      chk("locked_level", {31'b0, oLocked}, 32'd1);
      chk("locked_h_total", {20'b0, oH_Total}, 32'(H_TOT));
      chk("locked_v_total", {20'b0, oV_Total}, 32'(V_TOT));
      chk("locked_h_sync_w", {20'b0, oH_Sync_Width}, 32'(EXP_HSW));
      chk("locked_v_sync_w", {20'b0, oV_Sync_Width}, 32'(EXP_VSW));

      drive_frame(1'b1, 6, -1, 1'b0);
      chk("loss_locked", {31'b0, oLocked}, 32'd0);
      chk("loss_totals", {8'b0, oH_Total, oV_Total}, 32'd0);
      chk("loss_sync_w", {8'b0, oH_Sync_Width, oV_Sync_Width}, 32'd0);

      repeat (3) drive_frame(1'b0, -1, -1, 1'b0);
      drive_frame(1'b1, -1, -1, 1'b1);
      drive_frame(1'b1, -1, 5 * H_TOT + 15, 1'b0);
      chk("pre_rst_valid", {31'b0, oPixel_Valid}, 32'd1);
      chk("pre_rst_x", {20'b0, oX}, 32'd1);
      chk("pre_rst_y", {20'b0, oY}, 32'd1);

      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk_all_zero("midframe_rst");
      px_q.delete();
      lk_q.delete();
      hs = 1'b1;
      vs = 1'b1;
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      repeat (3) drive_frame(1'b0, -1, -1, 1'b0);
      drive_frame(1'b1, -1, -1, 1'b1);
      lk_q.push_back('{at: 32'(last_hfall_cyc + 4099), lvl: 1'b0});
      repeat (5000) @(negedge clk);
      chk("lost_locked", {31'b0, oLocked}, 32'd0);
      chk("lost_valid", {31'b0, oPixel_Valid}, 32'd0);
      chk("lost_totals", {8'b0, oH_Total, oV_Total}, 32'd0);

      repeat (5) @(negedge clk);
      chk("pixels_outstanding", 32'(px_q.size()), 32'd0);
      chk("lock_edges_outstanding", 32'(lk_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
